// File: rtl/sdc_data_ctrl_if.sv
// sdc_data_ctrl_if: configuration, command, status and control bundle of the SD data-transfer sequencer
//   cfg_*        transfer configuration (block count, per-block timeout, bus width)
//   *_start/abort  single-cycle command pulses
//   rx_*/tx_*    receiver/transmitter status; dat0_busy, fifo_* card and DMA status
//   rx_en/tx_en/lane_mask/blk_remaining/busy/done/irq_events  sequencer outputs
interface sdc_data_ctrl_if #(
    parameter int BLKCNT_W       = 16,
    parameter int DATA_TIMEOUT_W = 24,
    parameter int MAX_LANES      = 4
);
    logic [BLKCNT_W-1:0]       cfg_block_count;
    logic [DATA_TIMEOUT_W-1:0] cfg_timeout;
    logic [1:0]                cfg_bus_width;
    logic                      rx_start;
    logic                      tx_start;
    logic                      abort;
    logic                      rx_blk_done;
    logic                      rx_crc_err;
    logic                      rx_frame_err;
    logic                      rx_idle;
    logic                      tx_blk_done;
    logic [2:0]                tx_crc_status;
    logic                      dat0_busy;
    logic                      fifo_underflow;
    logic                      fifo_overflow;
    logic                      rx_en;
    logic                      tx_en;
    logic [MAX_LANES-1:0]      lane_mask;
    logic [BLKCNT_W-1:0]       blk_remaining;
    logic                      busy;
    logic                      done;
    logic [7:0]                irq_events;

    modport master (
        output cfg_block_count, cfg_timeout, cfg_bus_width, rx_start, tx_start, abort,
               rx_blk_done, rx_crc_err, rx_frame_err, rx_idle, tx_blk_done, tx_crc_status,
               dat0_busy, fifo_underflow, fifo_overflow,
        input  rx_en, tx_en, lane_mask, blk_remaining, busy, done, irq_events
    );

    modport slave (
        input  cfg_block_count, cfg_timeout, cfg_bus_width, rx_start, tx_start, abort,
               rx_blk_done, rx_crc_err, rx_frame_err, rx_idle, tx_blk_done, tx_crc_status,
               dat0_busy, fifo_underflow, fifo_overflow,
        output rx_en, tx_en, lane_mask, blk_remaining, busy, done, irq_events
    );
endinterface

// File: rtl/sdc_data_ctrl.sv
// sdc_data_ctrl: SD data-transfer sequencer driving rx/tx/DMA enables and the interrupt event vector
//   i_sd_clk    SD-side clock, rising edge
//   i_sd_rst_n  asynchronous active-low reset
//   bus         sdc_data_ctrl_if slave: configuration, commands, path status in; enables, counters, events out
module sdc_data_ctrl #(
    parameter int BLKCNT_W       = 16,
    parameter int DATA_TIMEOUT_W = 24,
    parameter int MAX_LANES      = 4
) (
    input logic            i_sd_clk,
    input logic            i_sd_rst_n,
    sdc_data_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RX_ACT, TX_ACT, TX_BUSY, DRAIN} state_t;

    state_t                    r_state, w_state_nxt;
    logic [BLKCNT_W-1:0]       r_blk_rem, w_blk_rem_nxt, w_blk_dec;
    logic [DATA_TIMEOUT_W-1:0] r_tmo;
    logic [MAX_LANES-1:0]      r_lane_mask, w_lane_mask_nxt, w_lane_dec;
    // r_err holds irq bits 7..2 (index = bit - 2)
    logic [5:0]                r_err, w_err_nxt;
    logic                      r_ok, w_ok_nxt;
    logic                      r_last, w_last_nxt;
    logic                      r_done, w_done_nxt;
    logic                      w_active, w_tmo_hit, w_blk_done;

    assign w_active   = r_state inside {RX_ACT, TX_ACT, TX_BUSY};
    assign w_tmo_hit  = w_active && bus.cfg_timeout != '0 &&
                        r_tmo + DATA_TIMEOUT_W'(1) == bus.cfg_timeout;
    assign w_blk_done = (r_state == RX_ACT && bus.rx_blk_done) || (r_state == TX_ACT && bus.tx_blk_done);
    // count 0 means open-ended, so the remaining counter parks at 0
    assign w_blk_dec  = r_blk_rem - BLKCNT_W'(r_blk_rem != '0);
    // widths the hardware cannot carry, and the reserved code, fall back to one lane
    assign w_lane_dec = (bus.cfg_bus_width == 2'd2 && MAX_LANES >= 8) ? MAX_LANES'(8'hFF) :
                        (bus.cfg_bus_width == 2'd1 && MAX_LANES >= 4) ? MAX_LANES'(8'h0F) :
                                                                        MAX_LANES'(8'h01);

    always_comb begin
        w_state_nxt     = r_state;
        w_blk_rem_nxt   = r_blk_rem;
        w_lane_mask_nxt = r_lane_mask;
        w_err_nxt       = r_err;
        w_ok_nxt        = r_ok;
        w_last_nxt      = r_last;
        w_done_nxt      = 1'b0;
        if (r_state == IDLE) begin
            if (bus.rx_start || bus.tx_start) begin
                w_state_nxt     = bus.rx_start ? RX_ACT : TX_ACT;
                w_blk_rem_nxt   = bus.cfg_block_count;
                w_lane_mask_nxt = w_lane_dec;
                w_err_nxt       = '0;
                w_ok_nxt        = 1'b0;
                w_last_nxt      = 1'b0;
            end
        end else if (bus.abort) begin
            w_err_nxt[5] = 1'b1;
            w_state_nxt  = DRAIN;
        end else if (w_tmo_hit) begin
            w_err_nxt[2] = 1'b1;
            w_state_nxt  = DRAIN;
        end else begin
            case (r_state)
                RX_ACT: begin
                    if (bus.rx_blk_done) begin
                        w_blk_rem_nxt = w_blk_dec;
                        w_err_nxt[0]  = r_err[0] | bus.rx_crc_err;
                        w_err_nxt[3]  = r_err[3] | bus.rx_frame_err;
                        // a pending FIFO error is honoured here, at the block boundary
                        if (r_blk_rem == BLKCNT_W'(1) || bus.rx_crc_err || bus.rx_frame_err || r_err[1])
                            w_state_nxt = DRAIN;
                    end else if (bus.fifo_overflow) begin
                        w_err_nxt[1] = 1'b1;
                    end
                end
                TX_ACT: begin
                    if (bus.tx_blk_done) begin
                        w_blk_rem_nxt = w_blk_dec;
                        w_last_nxt    = r_blk_rem == BLKCNT_W'(1);
                        w_err_nxt[4]  = r_err[4] | (bus.tx_crc_status != 3'b010);
                        w_err_nxt[0]  = r_err[0] | (bus.tx_crc_status == 3'b101);
                        w_state_nxt   = TX_BUSY;
                    end else if (bus.fifo_underflow) begin
                        w_err_nxt[1] = 1'b1;
                    end
                end
                TX_BUSY: if (!bus.dat0_busy) w_state_nxt = (r_last || r_err != '0) ? DRAIN : TX_ACT;
                DRAIN: begin
                    if (bus.rx_idle && !bus.dat0_busy) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                        w_ok_nxt    = r_err == '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_sd_clk or negedge i_sd_rst_n) begin
        if (!i_sd_rst_n) begin
            r_state     <= IDLE;
            r_blk_rem   <= '0;
            r_lane_mask <= MAX_LANES'(1);
            r_err       <= '0;
            r_ok        <= 1'b0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
            r_tmo       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_blk_rem   <= w_blk_rem_nxt;
            r_lane_mask <= w_lane_mask_nxt;
            r_err       <= w_err_nxt;
            r_ok        <= w_ok_nxt;
            r_last      <= w_last_nxt;
            r_done      <= w_done_nxt;
            r_tmo       <= (w_state_nxt != r_state || w_blk_done) ? '0 :
                           (w_active && bus.cfg_timeout != '0) ? r_tmo + DATA_TIMEOUT_W'(1) : r_tmo;
        end
    end

    assign bus.rx_en         = r_state == RX_ACT;
    assign bus.tx_en         = r_state == TX_ACT || r_state == TX_BUSY;
    assign bus.lane_mask     = r_lane_mask;
    assign bus.blk_remaining = r_blk_rem;
    assign bus.busy          = r_state != IDLE;
    assign bus.done          = r_done;
    assign bus.irq_events    = bus.busy ? 8'h00 : {r_err, r_err != '0, r_ok};
endmodule
